// File: rtl/fft_out_reorder.sv
// rtl/fft_out_reorder.sv - bit-reversed to natural order reorder buffer for the 16-point FFT output
// Define FFT_REORDER_PINGPONG_EN for two frame banks; default build uses a single bank.
module fft_out_reorder #(
    parameter int DATA_WIDTH = 12,
    parameter int N_LOG2     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_r,
    input  logic [DATA_WIDTH-1:0] in_i,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_r,
    output logic [DATA_WIDTH-1:0] out_i,
    output logic [N_LOG2-1:0]     out_idx,
    output logic                  out_last
);

    localparam int N = 2 ** N_LOG2;
    localparam logic [N_LOG2-1:0] LAST = N_LOG2'(N - 1);
`ifdef FFT_REORDER_PINGPONG_EN
    localparam int NBANK = 2;
`else
    localparam int NBANK = 1;
`endif

    logic [2*DATA_WIDTH-1:0] r_mem [NBANK][N];
    logic [N_LOG2-1:0]       r_wcnt;
    logic [N_LOG2-1:0]       r_rcnt;
    logic [NBANK-1:0]        r_full;
    logic                    r_wbank;
    logic                    r_rbank;

    logic                    w_wr;
    logic                    w_rd;
    logic [N_LOG2-1:0]       w_waddr;
    logic [2*DATA_WIDTH-1:0] w_rdata;

    always_comb begin
        w_waddr = '0;
        for (int b = 0; b < N_LOG2; b++) begin
            w_waddr[b] = r_wcnt[N_LOG2-1-b];
        end
    end

    // rst gates the handshakes combinationally so nothing moves during the reset cycle
    assign in_ready  = !rst && !r_full[r_wbank];
    assign out_valid = !rst && r_full[r_rbank];
    assign w_wr      = in_valid && in_ready;
    assign w_rd      = out_valid && out_ready;
    assign w_rdata   = r_mem[r_rbank][r_rcnt];
    assign out_r     = out_valid ? w_rdata[2*DATA_WIDTH-1:DATA_WIDTH] : '0;
    assign out_i     = out_valid ? w_rdata[DATA_WIDTH-1:0] : '0;
    assign out_idx   = r_rcnt;
    assign out_last  = out_valid && (r_rcnt == LAST);

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wbank][w_waddr] <= {in_r, in_i};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wcnt  <= '0;
            r_rcnt  <= '0;
            r_full  <= '0;
            r_wbank <= 1'b0;
            r_rbank <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wcnt <= r_wcnt + 1'b1;
                if (r_wcnt == LAST) begin
                    r_full[r_wbank] <= 1'b1;
`ifdef FFT_REORDER_PINGPONG_EN
                    r_wbank <= ~r_wbank;
`else
                    r_wbank <= 1'b0;
`endif
                end
            end
            // a final read clears the other bank than a same-cycle final write sets
            if (w_rd) begin
                r_rcnt <= r_rcnt + 1'b1;
                if (r_rcnt == LAST) begin
                    r_full[r_rbank] <= 1'b0;
`ifdef FFT_REORDER_PINGPONG_EN
                    r_rbank <= ~r_rbank;
`else
                    r_rbank <= 1'b0;
`endif
                end
            end
        end
    end

endmodule
